// File: rtl/ro_puf_challenger.sv
// Ring-oscillator PUF challenger: LFSR-driven challenge pairs, windowed edge counting,
// response collection and Hamming-distance check. Optional tie counter: PUF_TIE_FLAG_EN.
module ro_puf_challenger #(
  parameter int RESP_BITS  = 16,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 8,
  parameter int WINDOW_CYC = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           seed,
  input  logic [RESP_BITS-1:0] expected,
  input  logic [7:0]           hd_threshold,
  input  logic                 osc_a,
  input  logic                 osc_b,
  output logic [4:0]           sel_a,
  output logic [4:0]           sel_b,
  output logic                 osc_en,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 pass,
  output logic [7:0]           tie_cnt
);

  localparam int TMR_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = $clog2(RESP_BITS);
  localparam int HD_W    = $clog2(RESP_BITS + 1);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_COMPARE = 3'd3,
    ST_NEXT    = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  function automatic logic [HD_W-1:0] popcount(input logic [RESP_BITS-1:0] v);
    logic [HD_W-1:0] c;
    c = {HD_W{1'b0}};
    for (int i = 0; i < RESP_BITS; i++) begin
      c = c + HD_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  state_t                 state_r, state_next_s;
  logic [7:0]             lfsr_r;
  logic [4:0]             sel_a_r, sel_b_r;
  logic                   osc_en_r, busy_r, done_r, pass_r;
  logic [RESP_BITS-1:0]   response_r;
  logic [IDX_W-1:0]       bit_idx_r;
  logic [TMR_W-1:0]       timer_r;
  logic [CNT_W-1:0]       cnt_a_r, cnt_b_r;
  logic [2:0]             sync_a_r, sync_b_r;
  logic                   edge_a_s, edge_b_s, bit_s;
  logic [7:0]             seed_eff_s, lfsr_adv_s;
  logic [HD_W-1:0]        hd_s;

  assign seed_eff_s = (seed == 8'h00) ? 8'hA5 : seed;
  assign lfsr_adv_s = lfsr_step(lfsr_r);
  assign edge_a_s   = sync_a_r[1] & ~sync_a_r[2];
  assign edge_b_s   = sync_b_r[1] & ~sync_b_r[2];
  assign bit_s      = (cnt_a_r > cnt_b_r);
  assign hd_s       = popcount(response_r ^ expected);

  // Two-flop synchronizers followed by an edge-detect flop per oscillator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_r <= 3'b000;
      sync_b_r <= 3'b000;
    end else begin
      sync_a_r <= {sync_a_r[1:0], osc_a};
      sync_b_r <= {sync_b_r[1:0], osc_b};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_SETTLE;
        else       state_next_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (timer_r == SETTLE_LAST) state_next_s = ST_MEASURE;
        else                        state_next_s = ST_SETTLE;
      end
      ST_MEASURE: begin
        if (timer_r == WINDOW_LAST) state_next_s = ST_COMPARE;
        else                        state_next_s = ST_MEASURE;
      end
      ST_COMPARE: state_next_s = ST_NEXT;
      ST_NEXT: begin
        if (bit_idx_r == IDX_LAST) state_next_s = ST_CHECK;
        else                       state_next_s = ST_SETTLE;
      end
      ST_CHECK: state_next_s = ST_DONE;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Phase timer restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= {TMR_W{1'b0}};
    end else if ((state_next_s != state_r) || (state_r == ST_IDLE)) begin
      timer_r <= {TMR_W{1'b0}};
    end else begin
      timer_r <= timer_r + TMR_W'(1'b1);
    end
  end

  // Saturating edge counters: cleared while settling, counting only in the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_r <= {CNT_W{1'b0}};
      cnt_b_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_SETTLE: begin
          cnt_a_r <= {CNT_W{1'b0}};
          cnt_b_r <= {CNT_W{1'b0}};
        end
        ST_MEASURE: begin
          if (edge_a_s && (cnt_a_r != CNT_MAX)) cnt_a_r <= cnt_a_r + CNT_W'(1'b1);
          if (edge_b_s && (cnt_b_r != CNT_MAX)) cnt_b_r <= cnt_b_r + CNT_W'(1'b1);
        end
        default: begin
          cnt_a_r <= cnt_a_r;
          cnt_b_r <= cnt_b_r;
        end
      endcase
    end
  end

  // Challenge generator, response shift register, bit index and pass verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r     <= 8'hA5;
      sel_a_r    <= 5'h00;
      sel_b_r    <= 5'h1F;
      response_r <= {RESP_BITS{1'b0}};
      bit_idx_r  <= {IDX_W{1'b0}};
      pass_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            lfsr_r     <= seed_eff_s;
            sel_a_r    <= seed_eff_s[4:0];
            sel_b_r    <= ~seed_eff_s[4:0];
            response_r <= {RESP_BITS{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            pass_r     <= 1'b0;
          end
        end
        ST_COMPARE: response_r <= {response_r[RESP_BITS-2:0], bit_s};
        ST_NEXT: begin
          lfsr_r    <= lfsr_adv_s;
          sel_a_r   <= lfsr_adv_s[4:0];
          sel_b_r   <= ~lfsr_adv_s[4:0];
          bit_idx_r <= bit_idx_r + IDX_W'(1'b1);
        end
        ST_CHECK: pass_r <= ({{(8-HD_W){1'b0}}, hd_s} <= hd_threshold);
        default: begin
          lfsr_r <= lfsr_r;
        end
      endcase
    end
  end

  // Status outputs registered from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_en_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      osc_en_r <= (state_next_s == ST_SETTLE) || (state_next_s == ST_MEASURE);
      busy_r   <= (state_next_s != ST_IDLE);
      done_r   <= (state_next_s == ST_DONE);
    end
  end

`ifdef PUF_TIE_FLAG_EN
  logic [7:0] tie_cnt_r;

  // Saturating count of equal-count comparisons in the current run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tie_cnt_r <= 8'h00;
    end else if ((state_r == ST_IDLE) && start) begin
      tie_cnt_r <= 8'h00;
    end else if ((state_r == ST_COMPARE) && (cnt_a_r == cnt_b_r) && (tie_cnt_r != 8'hFF)) begin
      tie_cnt_r <= tie_cnt_r + 8'h01;
    end else begin
      tie_cnt_r <= tie_cnt_r;
    end
  end

  assign tie_cnt = tie_cnt_r;
`else
  assign tie_cnt = 8'h00;
`endif

  assign sel_a    = sel_a_r;
  assign sel_b    = sel_b_r;
  assign osc_en   = osc_en_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign response = response_r;
  assign pass     = pass_r;

endmodule

// File: tb/tb_ro_puf_challenger.sv
// Self-checking bench for ro_puf_challenger: emulated oscillator banks (period per select)
// checked against a frequency-ordering reference model.
module tb_ro_puf_challenger;
  localparam int RB  = 8;
  localparam int LAT = RB * (4 + 64 + 2) + 2;

  logic clk, rst_n, start, osc_a, osc_b;
  logic [7:0] seed, hd_threshold;
  logic [RB-1:0] expected;
  logic [4:0] sel_a, sel_b, s_sel_a, s_sel_b;
  logic osc_en, busy, done, pass, s_osc_en, s_busy, s_done, s_pass;
  logic [RB-1:0] response, s_response;
  logic [7:0] tie_cnt, s_tie_cnt;

  int n_vec = 0;
  int n_fail = 0;
  int tab_a[32];
  int tab_b[32];

  // observations of the last run
  int lat, done_cnt, extra_done, n_chal;
  logic post_busy;
  logic [RB-1:0] o_resp, o_sresp, o_resp_late;
  logic o_pass, o_spass, o_pass_late;
  logic [7:0] o_tie, o_stie;
  logic [4:0] o_sa[RB];
  logic [4:0] o_sb[RB];

  // reference model results
  logic [RB-1:0] m_resp;
  logic m_pass;
  logic [7:0] m_tie;
  logic [4:0] m_sa[RB];
  logic [4:0] m_sb[RB];

  ro_puf_challenger #(.RESP_BITS(RB), .CNT_W(16), .SETTLE_CYC(4), .WINDOW_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .expected(expected),
    .hd_threshold(hd_threshold), .osc_a(osc_a), .osc_b(osc_b), .sel_a(sel_a), .sel_b(sel_b),
    .osc_en(osc_en), .busy(busy), .done(done), .response(response), .pass(pass), .tie_cnt(tie_cnt));

  ro_puf_challenger #(.RESP_BITS(RB), .CNT_W(4), .SETTLE_CYC(4), .WINDOW_CYC(64)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .expected(expected),
    .hd_threshold(hd_threshold), .osc_a(osc_a), .osc_b(osc_b), .sel_a(s_sel_a), .sel_b(s_sel_b),
    .osc_en(s_osc_en), .busy(s_busy), .done(s_done), .response(s_response), .pass(s_pass),
    .tie_cnt(s_tie_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // oscillator banks: each select drives a square wave of the tabulated period
  initial begin : osc_drv
    int wc;
    int pa;
    int pb;
    wc = 0;
    osc_a = 1'b0;
    osc_b = 1'b0;
    forever begin
      @(negedge clk);
      wc++;
      pa = tab_a[sel_a];
      pb = tab_b[sel_b];
      if (pa < 2) pa = 2;
      if (pb < 2) pb = 2;
      osc_a = ((wc % pa) < (pa / 2));
      osc_b = ((wc % pb) < (pb / 2));
    end
  end

  function automatic int rnd_period();
    case ($urandom_range(0, 3))
      0: return 4;
      1: return 6;
      2: return 8;
      default: return 16;
    endcase
  endfunction

  task automatic fill_tabs(input int pa, input int pb);
    for (int i = 0; i < 32; i++) begin
      tab_a[i] = (pa > 0) ? pa : rnd_period();
      tab_b[i] = (pb > 0) ? pb : rnd_period();
    end
  endtask

  // faster oscillator wins the comparison; equal periods give identical waveforms, hence a tie
  task automatic model_run(input logic [7:0] sd, input logic [RB-1:0] ex, input logic [7:0] thr);
    int l;
    int fb;
    int ties;
    int hd;
    l = (sd == 8'h00) ? 'hA5 : int'(sd);
    ties = 0;
    m_resp = '0;
    for (int k = 0; k < RB; k++) begin
      m_sa[k] = 5'(l % 32);
      m_sb[k] = 5'(31 - (l % 32));
      if (tab_a[m_sa[k]] == tab_b[m_sb[k]]) ties++;
      m_resp = {m_resp[RB-2:0], logic'(tab_a[m_sa[k]] < tab_b[m_sb[k]])};
      fb = ((l / 128) + (l / 32) + (l / 16) + (l / 8)) % 2;
      fb = (((l / 128) % 2) + ((l / 32) % 2) + ((l / 16) % 2) + ((l / 8) % 2)) % 2;
      l = ((l * 2) % 256) + fb;
    end
    hd = $countones(m_resp ^ ex);
    m_pass = (hd <= int'(thr));
`ifdef PUF_TIE_FLAG_EN
    m_tie = 8'(ties);
`else
    m_tie = 8'h00;
`endif
  endtask

  task automatic run_puf(input logic [7:0] sd, input logic [RB-1:0] ex, input logic [7:0] thr,
                         input int extra_at);
    int cyc;
    logic prev_en;
    seed = sd;
    expected = ex;
    hd_threshold = thr;
    @(posedge clk); #1;
    start = 1'b1;
    cyc = 0;
    lat = -1;
    done_cnt = 0;
    n_chal = 0;
    prev_en = osc_en;
    while ((cyc < 2000) && (lat < 0)) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == extra_at);
      if (osc_en && !prev_en) begin
        if (n_chal < RB) begin
          o_sa[n_chal] = sel_a;
          o_sb[n_chal] = sel_b;
        end
        n_chal++;
      end
      prev_en = osc_en;
      if (done) begin
        lat = cyc;
        done_cnt++;
      end
    end
    start = 1'b0;
    o_resp = response; o_sresp = s_response;
    o_pass = pass;     o_spass = s_pass;
    o_tie = tie_cnt;   o_stie = s_tie_cnt;
    extra_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    post_busy = busy;
    o_resp_late = response;
    o_pass_late = pass;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; seed = 8'h00; expected = '0; hd_threshold = 8'h00;
    fill_tabs(8, 8);
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %0h want 0", busy); end
    n_vec++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done got %0h want 0", done); end
    n_vec++; if (osc_en !== 1'b0)     begin n_fail++; $display("FAIL reset_osc_en got %0h want 0", osc_en); end
    n_vec++; if (response !== 8'h00)  begin n_fail++; $display("FAIL reset_response got %0h want 0", response); end
    n_vec++; if (pass !== 1'b0)       begin n_fail++; $display("FAIL reset_pass got %0h want 0", pass); end
    n_vec++; if (tie_cnt !== 8'h00)   begin n_fail++; $display("FAIL reset_tie got %0h want 0", tie_cnt); end
    n_vec++; if (sel_a !== 5'h00)     begin n_fail++; $display("FAIL reset_sel_a got %0h want 0", sel_a); end
    n_vec++; if (sel_b !== 5'h1F)     begin n_fail++; $display("FAIL reset_sel_b got %0h want 1f", sel_b); end
    n_vec++; if (dut.lfsr_r !== 8'hA5) begin n_fail++; $display("FAIL reset_lfsr got %0h want a5", dut.lfsr_r); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_freq_mismatch();
    fill_tabs(4, 8);
    run_puf(8'h3C, 8'hFF, 8'h00, 100);
    n_vec++; if (lat != LAT)            begin n_fail++; $display("FAIL mismatch_latency got %0d want %0d", lat, LAT); end
    n_vec++; if (o_resp !== 8'hFF)      begin n_fail++; $display("FAIL mismatch_response got %0h want ff", o_resp); end
    n_vec++; if (o_pass !== 1'b1)       begin n_fail++; $display("FAIL mismatch_pass got %0h want 1", o_pass); end
    n_vec++; if (done_cnt != 1)         begin n_fail++; $display("FAIL mismatch_done_pulses got %0d want 1", done_cnt); end
    n_vec++; if (extra_done != 0)       begin n_fail++; $display("FAIL ignored_start_second_done got %0d want 0", extra_done); end
    n_vec++; if (post_busy !== 1'b0)    begin n_fail++; $display("FAIL ignored_start_busy got %0h want 0", post_busy); end
    n_vec++; if (o_resp_late !== 8'hFF) begin n_fail++; $display("FAIL response_hold got %0h want ff", o_resp_late); end
    n_vec++; if (o_pass_late !== 1'b1)  begin n_fail++; $display("FAIL pass_hold got %0h want 1", o_pass_late); end
  endtask

  task automatic test_hamming();
    fill_tabs(4, 8);
    run_puf(8'h3C, 8'h0F, 8'd3, -1);
    n_vec++; if (o_pass !== 1'b0) begin n_fail++; $display("FAIL hd_thr3_pass got %0h want 0", o_pass); end
    run_puf(8'h3C, 8'h0F, 8'd4, -1);
    n_vec++; if (o_pass !== 1'b1) begin n_fail++; $display("FAIL hd_thr4_pass got %0h want 1", o_pass); end
  endtask

  task automatic test_equal();
    logic [7:0] want_tie;
`ifdef PUF_TIE_FLAG_EN
    want_tie = 8'd8;
`else
    want_tie = 8'd0;
`endif
    fill_tabs(8, 8);
    run_puf(8'h3C, 8'h00, 8'h00, -1);
    n_vec++; if (o_resp !== 8'h00)  begin n_fail++; $display("FAIL equal_response got %0h want 0", o_resp); end
    n_vec++; if (o_tie !== want_tie) begin n_fail++; $display("FAIL equal_tie got %0d want %0d", o_tie, want_tie); end
    n_vec++; if (o_pass !== 1'b1)   begin n_fail++; $display("FAIL equal_pass got %0h want 1", o_pass); end
  endtask

  task automatic test_sequencing();
    fill_tabs(0, 0);
    model_run(8'h3C, 8'h00, 8'h08);
    run_puf(8'h3C, 8'h00, 8'h08, -1);
    n_vec++; if (o_sa[0] !== 5'h1C) begin n_fail++; $display("FAIL seq_sel_a0 got %0h want 1c", o_sa[0]); end
    n_vec++; if (o_sb[0] !== 5'h03) begin n_fail++; $display("FAIL seq_sel_b0 got %0h want 03", o_sb[0]); end
    n_vec++; if (o_sa[1] !== 5'h19) begin n_fail++; $display("FAIL seq_sel_a1 got %0h want 19", o_sa[1]); end
    n_vec++; if (n_chal != RB)      begin n_fail++; $display("FAIL seq_challenges got %0d want %0d", n_chal, RB); end
    for (int k = 0; k < RB; k++) begin
      n_vec++; if (o_sa[k] !== m_sa[k]) begin n_fail++; $display("FAIL seq_sel_a[%0d] got %0h want %0h", k, o_sa[k], m_sa[k]); end
      n_vec++; if (o_sb[k] !== m_sb[k]) begin n_fail++; $display("FAIL seq_sel_b[%0d] got %0h want %0h", k, o_sb[k], m_sb[k]); end
    end
    n_vec++; if (o_resp !== m_resp) begin n_fail++; $display("FAIL seq_response got %0h want %0h", o_resp, m_resp); end
  endtask

  task automatic test_saturation();
    fill_tabs(4, 8);
    run_puf(8'h3C, 8'hFF, 8'h00, -1);
    n_vec++; if (o_sresp !== 8'hFF) begin n_fail++; $display("FAIL sat_response got %0h want ff", o_sresp); end
    n_vec++; if (o_spass !== 1'b1)  begin n_fail++; $display("FAIL sat_pass got %0h want 1", o_spass); end
    n_vec++; if (o_stie !== 8'h00)  begin n_fail++; $display("FAIL sat_tie got %0d want 0", o_stie); end
  endtask

  task automatic test_reset_mid_run();
    fill_tabs(4, 8);
    seed = 8'h3C; expected = 8'hFF; hd_threshold = 8'h00;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (239) @(posedge clk);
    #1;
    n_vec++; if (response !== 8'h07) begin n_fail++; $display("FAIL midrun_partial got %0h want 07", response); end
    n_vec++; if (osc_en !== 1'b1)    begin n_fail++; $display("FAIL midrun_osc_en got %0h want 1", osc_en); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy got %0h want 0", busy); end
    n_vec++; if (osc_en !== 1'b0)     begin n_fail++; $display("FAIL rst_osc_en got %0h want 0", osc_en); end
    n_vec++; if (response !== 8'h00)  begin n_fail++; $display("FAIL rst_response got %0h want 0", response); end
    n_vec++; if (dut.lfsr_r !== 8'hA5) begin n_fail++; $display("FAIL rst_lfsr got %0h want a5", dut.lfsr_r); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_puf(8'h3C, 8'hFF, 8'h00, -1);
    n_vec++; if (lat != LAT)       begin n_fail++; $display("FAIL rerun_latency got %0d want %0d", lat, LAT); end
    n_vec++; if (o_resp !== 8'hFF) begin n_fail++; $display("FAIL rerun_response got %0h want ff", o_resp); end
  endtask

  task automatic test_random();
    logic [7:0] sd;
    logic [RB-1:0] ex;
    logic [7:0] thr;
    for (int it = 0; it < 6; it++) begin
      fill_tabs(0, 0);
      sd  = (it == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      ex  = RB'($urandom);
      thr = 8'($urandom_range(0, 8));
      model_run(sd, ex, thr);
      run_puf(sd, ex, thr, int'($urandom_range(2, 500)));
      n_vec++; if (lat != LAT)        begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", it, lat, LAT); end
      n_vec++; if (o_resp !== m_resp) begin n_fail++; $display("FAIL rnd%0d_response got %0h want %0h", it, o_resp, m_resp); end
      n_vec++; if (o_pass !== m_pass) begin n_fail++; $display("FAIL rnd%0d_pass got %0h want %0h", it, o_pass, m_pass); end
      n_vec++; if (o_tie !== m_tie)   begin n_fail++; $display("FAIL rnd%0d_tie got %0d want %0d", it, o_tie, m_tie); end
      n_vec++; if (o_sresp !== m_resp) begin n_fail++; $display("FAIL rnd%0d_sat_response got %0h want %0h", it, o_sresp, m_resp); end
      n_vec++; if (o_sa[RB-1] !== m_sa[RB-1]) begin n_fail++; $display("FAIL rnd%0d_last_sel_a got %0h want %0h", it, o_sa[RB-1], m_sa[RB-1]); end
      n_vec++; if (extra_done != 0)   begin n_fail++; $display("FAIL rnd%0d_extra_done got %0d want 0", it, extra_done); end
    end
  endtask

  initial begin
    test_reset();
    test_freq_mismatch();
    test_hamming();
    test_equal();
    test_sequencing();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
